// File: rtl/seq_alu.sv
// Registered EX-stage ALU: single-cycle logic/arith/shift/compare ops plus
// radix-2 shift-add MULTU and restoring DIVU behind a start/busy/valid handshake.
module seq_alu #(
    parameter int  WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       ALUctl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] ALUOut,
    output logic [WIDTH-1:0] ALUOut_hi,
    output logic             Zero,
    output logic             busy_o,
    output logic             valid_o,
    output logic             div0_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int HW = WIDTH / 2;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SRLV = 4'd3;
    localparam logic [3:0] OP_SRL  = 4'd4;
    localparam logic [3:0] OP_LUI  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_ORI  = 4'd8;
    localparam logic [3:0] OP_EQ   = 4'd9;
    localparam logic [3:0] OP_SLT  = 4'd10;
    localparam logic [3:0] OP_SRA  = 4'd11;
    localparam logic [3:0] OP_MULU = 4'd12;
    localparam logic [3:0] OP_DIVU = 4'd13;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;     // running high product / partial remainder
    logic [WIDTH-1:0] wrk_q;     // multiplier being consumed / dividend-then-quotient
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] alu_out_q;
    logic [WIDTH-1:0] alu_hi_q;
    logic             valid_q;
    logic             div0_q;

    logic [WIDTH-1:0] res_d;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_acc_d;
    logic [WIDTH-1:0] mul_wrk_d;
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_acc_d;
    logic [WIDTH-1:0] div_wrk_d;

    always_comb begin
        res_d = '0;
        case (ALUctl)
            OP_AND:  res_d = A & B;
            OP_OR:   res_d = A | B;
            OP_ADD:  res_d = A + B;
            OP_SRLV: res_d = B >> A[SHW-1:0];
            OP_SRL:  res_d = B >> shamt;
            OP_LUI:  res_d = B << HW;
            OP_SUB:  res_d = A - B;
            OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_ORI:  res_d = A | {{HW{1'b0}}, B[HW-1:0]};
            OP_EQ:   res_d = {{(WIDTH-1){1'b0}}, (A == B)};
            OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SRA:  res_d = WIDTH'($signed(B) >>> shamt);
            default: res_d = '0;
        endcase
    end

    // Shift-add step: the carry out of the add becomes the new MSB of the pair.
    always_comb begin
        mul_sum   = {1'b0, acc_q} + (wrk_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        mul_acc_d = mul_sum[WIDTH:1];
        mul_wrk_d = {mul_sum[0], wrk_q[WIDTH-1:1]};
    end

    // Restoring step; the remainder is always < divisor, so the low bits suffice.
    always_comb begin
        div_sh    = {acc_q, wrk_q[WIDTH-1]};
        div_ge    = (div_sh >= {1'b0, b_q});
        div_acc_d = div_ge ? (div_sh[WIDTH-1:0] - b_q) : div_sh[WIDTH-1:0];
        div_wrk_d = {wrk_q[WIDTH-2:0], div_ge};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            b_q       <= '0;
            acc_q     <= '0;
            wrk_q     <= '0;
            cnt_q     <= '0;
            alu_out_q <= '0;
            alu_hi_q  <= '0;
            valid_q   <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        if (ALUctl == OP_MULU) begin
                            b_q     <= B;
                            wrk_q   <= A;
                            acc_q   <= '0;
                            cnt_q   <= CW'(WIDTH);
                            state_q <= S_MUL;
                        end else if (ALUctl == OP_DIVU && B != '0) begin
                            b_q     <= B;
                            wrk_q   <= A;
                            acc_q   <= '0;
                            cnt_q   <= CW'(WIDTH);
                            state_q <= S_DIV;
                        end else if (ALUctl == OP_DIVU) begin
                            alu_out_q <= '1;
                            alu_hi_q  <= A;
                            div0_q    <= 1'b1;
                            valid_q   <= 1'b1;
                        end else begin
                            alu_out_q <= res_d;
                            alu_hi_q  <= '0;
                            div0_q    <= 1'b0;
                            valid_q   <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc_q <= mul_acc_d;
                    wrk_q <= mul_wrk_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        alu_out_q <= mul_wrk_d;
                        alu_hi_q  <= mul_acc_d;
                        div0_q    <= 1'b0;
                        valid_q   <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
                S_DIV: begin
                    acc_q <= div_acc_d;
                    wrk_q <= div_wrk_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        alu_out_q <= div_wrk_d;
                        alu_hi_q  <= div_acc_d;
                        div0_q    <= 1'b0;
                        valid_q   <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ALUOut    = alu_out_q;
    assign ALUOut_hi = alu_hi_q;
    assign Zero      = (alu_out_q == '0);
    assign busy_o    = (state_q != S_IDLE);
    assign valid_o   = valid_q;
    assign div0_o    = div0_q;

endmodule

// File: tb/tb_seq_alu.sv
// Randomized + directed bench for seq_alu at WIDTH=32 and WIDTH=8, checked
// against an arithmetic reference model of the op map and latencies.
module tb_seq_alu;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        s32;
    logic [3:0]  c32;
    logic [31:0] a32, b32, o32, h32;
    logic [4:0]  sh32;
    logic        z32, busy32, v32, d32;

    logic        s8;
    logic [3:0]  c8;
    logic [7:0]  a8, b8, o8, h8;
    logic [2:0]  sh8;
    logic        z8, busy8, v8, d8;

    seq_alu #(.WIDTH(32)) dut32 (
        .clk_i(clk), .rst_i(rst), .start_i(s32), .ALUctl(c32), .A(a32), .B(b32),
        .shamt(sh32), .ALUOut(o32), .ALUOut_hi(h32), .Zero(z32), .busy_o(busy32),
        .valid_o(v32), .div0_o(d32)
    );

    seq_alu #(.WIDTH(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(s8), .ALUctl(c8), .A(a8), .B(b8),
        .shamt(sh8), .ALUOut(o8), .ALUOut_hi(h8), .Zero(z8), .busy_o(busy8),
        .valid_o(v8), .div0_o(d8)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [63:0] lo;
        logic [63:0] hi;
        logic        d0;
        int          lat;
    } res_t;

    // Reference: plain arithmetic on 64-bit values, masked to w bits.
    function automatic res_t model(input int w, input int ctl, input logic [63:0] a_in,
                                   input logic [63:0] b_in, input logic [63:0] sh_in);
        res_t r;
        logic [63:0] mask, a, b, sh, shm, t, p;
        longint sa, sb;
        mask = (64'd1 << w) - 64'd1;
        shm  = (w == 8) ? 64'd7 : 64'd31;
        a = a_in & mask;
        b = b_in & mask;
        sh = sh_in & shm;
        r.lo = 0; r.hi = 0; r.d0 = 1'b0; r.lat = 1;
        case (ctl)
            0:  r.lo = a & b;
            1:  r.lo = a | b;
            2:  r.lo = (a + b) & mask;
            3:  r.lo = b >> (a & shm);
            4:  r.lo = b >> sh;
            5:  r.lo = (b << (w / 2)) & mask;
            6:  r.lo = (a - b) & mask;
            7:  r.lo = (a < b) ? 64'd1 : 64'd0;
            8:  r.lo = a | (b & ((64'd1 << (w / 2)) - 64'd1));
            9:  r.lo = (a == b) ? 64'd1 : 64'd0;
            10: begin
                sa = longint'(a) - (a[w-1] ? (longint'(1) << w) : longint'(0));
                sb = longint'(b) - (b[w-1] ? (longint'(1) << w) : longint'(0));
                r.lo = (sa < sb) ? 64'd1 : 64'd0;
            end
            11: begin
                t = b >> sh;
                if (b[w-1]) t = t | (mask & ~(mask >> sh));
                r.lo = t;
            end
            12: begin
                p = a * b;
                r.lo = p & mask;
                r.hi = p >> w;
                r.lat = w + 1;
            end
            13: begin
                if (b == 0) begin
                    r.lo = mask; r.hi = a; r.d0 = 1'b1;
                end else begin
                    r.lo = a / b; r.hi = a % b; r.lat = w + 1;
                end
            end
            default: r.lo = 0;
        endcase
        return r;
    endfunction

    task automatic drive(input int w, input logic st, input int ctl, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] sh);
        if (w == 8) begin
            s8 = st; c8 = 4'(ctl); a8 = a[7:0]; b8 = b[7:0]; sh8 = sh[2:0];
        end else begin
            s32 = st; c32 = 4'(ctl); a32 = a[31:0]; b32 = b[31:0]; sh32 = sh[4:0];
        end
    endtask

    function automatic logic [63:0] get_lo(input int w);
        return (w == 8) ? {56'd0, o8} : {32'd0, o32};
    endfunction
    function automatic logic [63:0] get_hi(input int w);
        return (w == 8) ? {56'd0, h8} : {32'd0, h32};
    endfunction
    function automatic logic get_valid(input int w);
        return (w == 8) ? v8 : v32;
    endfunction
    function automatic logic get_busy(input int w);
        return (w == 8) ? busy8 : busy32;
    endfunction
    function automatic logic get_zero(input int w);
        return (w == 8) ? z8 : z32;
    endfunction
    function automatic logic get_div0(input int w);
        return (w == 8) ? d8 : d32;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // One isolated op: inputs are scrambled after the start edge; optional stray start mid-op.
    task automatic run_op(input int w, input int ctl, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] sh, input bit poke);
        res_t e;
        int n;
        int busy_cnt;
        logic [63:0] lo_seen;
        e = model(w, ctl, a, b, sh);
        @(negedge clk);
        drive(w, 1'b1, ctl, a, b, sh);
        @(negedge clk);
        drive(w, 1'b0, int'($urandom_range(0, 15)), rnd64(), rnd64(), rnd64());
        n = 1;
        busy_cnt = 0;
        while (!get_valid(w) && n < 3 * w + 5) begin
            if (get_busy(w)) busy_cnt++;
            drive(w, poke && n == 5, 2, rnd64(), rnd64(), rnd64());
            @(negedge clk);
            n++;
        end
        $display("op w=%0d ctl=%0d a=0x%0h b=0x%0h sh=%0d -> lo=0x%0h hi=0x%0h d0=%0b lat=%0d",
                 w, ctl, a & ((64'd1 << w) - 1), b & ((64'd1 << w) - 1), sh,
                 get_lo(w), get_hi(w), get_div0(w), n);
        check_val($sformatf("lat ctl%0d", ctl), 64'(n), 64'(e.lat));
        check_val($sformatf("lo ctl%0d", ctl), get_lo(w), e.lo);
        check_val($sformatf("hi ctl%0d", ctl), get_hi(w), e.hi);
        check_val($sformatf("div0 ctl%0d", ctl), 64'(get_div0(w)), 64'(e.d0));
        check_val($sformatf("zero ctl%0d", ctl), 64'(get_zero(w)), 64'(e.lo == 0));
        check_val($sformatf("busycyc ctl%0d", ctl), 64'(busy_cnt), 64'(e.lat - 1));
        lo_seen = get_lo(w);
        @(negedge clk);
        check_val("valid_pulse", 64'(get_valid(w)), 64'd0);
        check_val("hold_lo", get_lo(w), lo_seen);
    endtask

    // Single-cycle ops issued on consecutive cycles; each result is due one edge later.
    task automatic b2b(input int w, input int n);
        res_t prev;
        int ctl;
        logic [63:0] a, b, sh;
        prev = model(w, 0, 0, 0, 0);
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            if (i > 0) begin
                $display("b2b w=%0d i=%0d lo=0x%0h exp=0x%0h", w, i, get_lo(w), prev.lo);
                check_val("b2b_valid", 64'(get_valid(w)), 64'd1);
                check_val("b2b_lo", get_lo(w), prev.lo);
                check_val("b2b_hi", get_hi(w), 64'd0);
            end
            if (i < n) begin
                ctl = int'($urandom_range(0, 13));
                if (ctl >= 12) ctl += 2;
                a = rnd64(); b = rnd64(); sh = 64'($urandom_range(0, w - 1));
                prev = model(w, ctl, a, b, sh);
                drive(w, 1'b1, ctl, a, b, sh);
            end else begin
                drive(w, 1'b0, 0, 0, 0, 0);
            end
        end
    endtask

    initial begin
        int w, ctl;
        logic [63:0] a, b;
        rst = 1'b1;
        drive(32, 1'b0, 0, 0, 0, 0);
        drive(8, 1'b0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_lo", get_lo(32), 64'd0);
        check_val("rst_hi", get_hi(32), 64'd0);
        check_val("rst_busy", 64'(get_busy(32)), 64'd0);
        check_val("rst_valid", 64'(get_valid(32)), 64'd0);
        check_val("rst_div0", 64'(get_div0(32)), 64'd0);

        run_op(32, 2, 64'h7FFFFFFF, 64'h1, 0, 0);
        run_op(32, 6, 64'd5, 64'd5, 0, 0);
        run_op(32, 10, 64'hFFFFFFFF, 64'd1, 0, 0);
        run_op(32, 7, 64'hFFFFFFFF, 64'd1, 0, 0);
        run_op(32, 11, 64'h0, 64'h80000000, 64'd4, 0);
        run_op(32, 3, 64'd36, 64'hF0, 0, 0);
        run_op(32, 5, 64'h0, 64'h1234, 0, 0);
        run_op(32, 8, 64'hFFFF0000, 64'hABCD1234, 0, 0);
        run_op(32, 4, 64'h0, 64'hDEADBEEF, 64'd0, 0);
        run_op(32, 12, 64'hFFFFFFFF, 64'hFFFFFFFF, 0, 1);
        run_op(32, 13, 64'd100, 64'd7, 0, 1);
        run_op(8, 12, 64'd200, 64'd200, 0, 0);
        run_op(8, 4, 64'h0, 64'h80, 64'd7, 0);
        run_op(8, 13, 64'd250, 64'd3, 0, 1);

        b2b(32, 12);
        b2b(8, 12);

        for (int i = 0; i < 60; i++) begin
            w = ($urandom_range(0, 1) == 1) ? 32 : 8;
            ctl = int'($urandom_range(0, 15));
            a = rnd64();
            b = rnd64();
            if (ctl == 13 && $urandom_range(0, 3) == 0) b = 0;
            else if (ctl == 13 && $urandom_range(0, 1) == 0) b = b & 64'hFF;
            run_op(w, ctl, a, b, 64'($urandom_range(0, w - 1)), bit'($urandom_range(0, 1)));
        end

        run_op(32, 13, 64'd5, 64'd0, 0, 0);

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk);
        drive(32, 1'b1, 12, 64'h12345678, 64'h9ABCDEF1, 0);
        @(negedge clk);
        drive(32, 1'b0, 0, 0, 0, 0);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        $display("midrst lo=0x%0h hi=0x%0h busy=%0b valid=%0b div0=%0b",
                 get_lo(32), get_hi(32), get_busy(32), get_valid(32), get_div0(32));
        check_val("midrst_lo", get_lo(32), 64'd0);
        check_val("midrst_hi", get_hi(32), 64'd0);
        check_val("midrst_busy", 64'(get_busy(32)), 64'd0);
        check_val("midrst_valid", 64'(get_valid(32)), 64'd0);
        check_val("midrst_div0", 64'(get_div0(32)), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check_val("postrst_novalid", 64'(get_valid(32)), 64'd0);
        end
        run_op(32, 2, 64'd3, 64'd4, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, registered successor of the single-cycle datapath ALU, with WIDTH-generic operands.
- Keeps the existing ALUctl op map (logic, add/sub, shifts, LUI, ORI, compare).
- Adds signed compare, arithmetic shift, and multi-cycle unsigned multiply and divide behind a start/busy/valid handshake.
- Sits in the EX stage of the multi-cycle CPU; the control unit stalls on busy_o.

Parameters:
WIDTH, 32, operand/result width; must be even, >= 8.
SHW, $clog2(WIDTH), shift-amount width (derived; not overridden).

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  reset, asynchronous, active-high
start_i  input  1  launch op; sampled only in IDLE
ALUctl  input  4  operation select
A  input  WIDTH  operand A (captured at start)
B  input  WIDTH  operand B (captured at start)
shamt  input  SHW  immediate shift amount (captured at start)
ALUOut  output  WIDTH  result / low product / quotient
ALUOut_hi  output  WIDTH  high product (MULTU), remainder (DIVU), else 0
Zero  output  1  ALUOut == 0 (combinational from registered ALUOut)
busy_o  output  1  high while a multi-cycle op is in progress
valid_o  output  1  one-cycle pulse: ALUOut/ALUOut_hi updated this cycle
div0_o  output  1  registered with result; set only by DIVU with B==0

Behaviour:
- Reset (async, any state): state=IDLE, ALUOut=0, ALUOut_hi=0, valid_o=0, busy_o=0, div0_o=0, counter=0, operand regs=0.
- Op map (A,B = captured operands; unsigned unless stated):
  - 0 AND
  - 1 OR
  - 2 ADD (mod 2^WIDTH)
  - 3 SRLV: B >> A[SHW-1:0]
  - 4 SRL: B >> shamt
  - 5 LUI: B << WIDTH/2
  - 6 SUB
  - 7 SLTU: A<B ? 1:0
  - 8 ORI: A | zero-extended B[WIDTH/2-1:0]
  - 9 EQ: A==B ? 1:0
  - 10 SLT, signed two's-complement
  - 11 SRA: arithmetic B >>> shamt
  - 12 MULTU
  - 13 DIVU
  - 14, 15: result 0, single-cycle
- States: IDLE, MUL, DIV.
- IDLE with start_i=1 and a single-cycle op (0-11, 14, 15):
  - At the sampling edge, ALUOut=result, ALUOut_hi=0, div0_o=0.
  - valid_o=1 for exactly the next cycle.
  - Latency 1 edge; back-to-back single-cycle starts accepted every cycle.
- IDLE with start_i=1 and ALUctl=12:
  - Capture A, B; go to MUL; counter=WIDTH.
  - One shift-add iteration per edge (radix-2).
  - On the edge where the counter reaches 0: {ALUOut_hi,ALUOut}=A*B (2*WIDTH bits), valid_o pulses, return to IDLE.
  - Latency WIDTH+1 edges from the start edge.
- IDLE with start_i=1 and ALUctl=13, B!=0:
  - Go to DIV; restoring division, one quotient bit per edge.
  - After WIDTH iterations: ALUOut=A/B, ALUOut_hi=A%B, valid_o pulses.
  - Latency WIDTH+1.
- DIVU with B==0:
  - No iteration; stays in IDLE.
  - Next edge: ALUOut=all ones, ALUOut_hi=A, div0_o=1, valid_o=1.
  - Latency 1.
- busy_o = (state!=IDLE); combinational.
- start_i while busy: ignored, no queuing. Input changes during MUL/DIV do not affect the result.
- Same-cycle completion and new start: not possible, since start is sampled only in IDLE. The first start is accepted on the edge after valid_o rises.
- Outputs hold their last result between operations; valid_o is 0 except for the one-cycle pulse.
- Shift amounts use only the low SHW bits; shift by 0 returns B unchanged.
- Reset asserted mid-MUL/DIV: abort immediately to reset values; no valid_o pulse.

Test Plan:
1. Reset then single ops, WIDTH=32:
   - ADD 0x7FFFFFFF+1 -> 0x80000000, valid_o 1 cycle after start.
   - SUB 5-5 -> 0, Zero=1.
   - SLT 0xFFFFFFFF<1 -> 1; SLTU same operands -> 0.
2. Shifts:
   - SRA 0x80000000 by shamt 4 -> 0xF8000000.
   - SRLV A=36 (low bits 4), B=0xF0 -> 0x0F.
   - LUI B=0x1234 -> 0x12340000.
   - ORI A=0xFFFF0000, B=0xABCD1234 -> 0xFFFF1234.
3. MULTU 0xFFFFFFFF*0xFFFFFFFF:
   - busy_o high for 32 cycles; result after 33 edges: hi=0xFFFFFFFE, lo=0x00000001.
   - start_i pulsed mid-op is ignored.
4. DIVU:
   - 100/7 -> ALUOut=14, ALUOut_hi=2, latency 33.
   - 5/0 -> ALUOut=0xFFFFFFFF, ALUOut_hi=5, div0_o=1, latency 1.
5. Reset at cycle 10 of a MULTU:
   - All outputs 0 asynchronously, busy_o=0, no valid_o.
   - Next ADD 3+4 -> 7 normally.
6. WIDTH=8 instance:
   - MULTU 200*200 -> hi=0x9C, lo=0x40, latency 9.
   - SRL by 7 of 0x80 -> 0x01.
